// File: rtl/reglk_programmer.sv
// Programs NB_REGS 32-bit register-lock words over an AXI-lite style master port,
// one transaction at a time, with an optional read-back compare of every word.
module reglk_programmer #(
  parameter int                        NB_REGS        = 6,
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          verify_en_i,
  input  logic [NB_REGS*32-1:0]         lock_val_i,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic [1:0]                    b_resp_i,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]     ar_addr_o,
  input  logic                          r_valid_i,
  output logic                          r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     r_data_i,
  input  logic [1:0]                    r_resp_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic [3:0]                    err_idx_o,
  output logic [1:0]                    err_type_o
);

  localparam int IDX_W = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_REGS - 1);

  localparam logic [1:0] ERR_BRESP = 2'b01;
  localparam logic [1:0] ERR_RRESP = 2'b10;
  localparam logic [1:0] ERR_CMP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, ERR
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 verify_q, verify_d;
  logic [3:0]           err_idx_q, err_idx_d;
  logic [1:0]           err_type_q, err_type_d;
  logic                 capture;
  logic [NB_REGS*32-1:0] lock_q;

  logic [31:0]               cur_word;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic                      aw_hs, w_hs;

  function automatic logic word_mismatch(input logic [AXI_DATA_WIDTH-1:0] rdata,
                                         input logic [31:0] expected);
    // Any nonzero upper bit counts as a mismatch as well.
    return rdata != AXI_DATA_WIDTH'(expected);
  endfunction

  assign cur_word = lock_q[32*int'(idx_q) +: 32];
  assign cur_addr = BASE_ADDR + (AXI_ADDR_WIDTH'(idx_q) << 3);

  assign aw_valid_o = (state_q == WR_REQ) && !aw_done_q;
  assign w_valid_o  = (state_q == WR_REQ) && !w_done_q;
  assign b_ready_o  = (state_q == WR_RESP);
  assign ar_valid_o = (state_q == RD_REQ);
  assign r_ready_o  = (state_q == RD_RESP);

  // Payloads are gated by their valid so the bus reads as zero whenever idle or in reset.
  assign aw_addr_o = aw_valid_o ? cur_addr : '0;
  assign ar_addr_o = ar_valid_o ? cur_addr : '0;
  assign w_data_o  = w_valid_o ? AXI_DATA_WIDTH'(cur_word) : '0;
  assign w_strb_o  = w_valid_o ? '1 : '0;

  assign busy_o     = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                      (state_q == RD_REQ) || (state_q == RD_RESP);
  assign done_o     = (state_q == DONE);
  assign error_o    = (state_q == ERR);
  assign err_idx_o  = err_idx_q;
  assign err_type_o = err_type_q;

  assign aw_hs = aw_valid_o && aw_ready_i;
  assign w_hs  = w_valid_o && w_ready_i;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    verify_d   = verify_q;
    err_idx_d  = err_idx_q;
    err_type_d = err_type_q;
    capture    = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          capture    = 1'b1;
          verify_d   = verify_en_i;
          idx_d      = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          err_idx_d  = '0;
          err_type_d = '0;
          state_d    = WR_REQ;
        end
      end
      WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_valid_i) begin
          if (b_resp_i != 2'b00) begin
            err_idx_d  = 4'(idx_q);
            err_type_d = ERR_BRESP;
            state_d    = ERR;
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = verify_q ? RD_REQ : DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (ar_ready_i) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (r_valid_i) begin
          if (r_resp_i != 2'b00) begin
            err_idx_d  = 4'(idx_q);
            err_type_d = ERR_RRESP;
            state_d    = ERR;
          end else if (word_mismatch(r_data_i, cur_word)) begin
            err_idx_d  = 4'(idx_q);
            err_type_d = ERR_CMP;
            state_d    = ERR;
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      verify_q   <= 1'b0;
      err_idx_q  <= '0;
      err_type_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      verify_q   <= verify_d;
      err_idx_q  <= err_idx_d;
      err_type_q <= err_type_d;
    end
  end

  // Lock words are pure data: only ever read after a capture, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (capture) lock_q <= lock_val_i;
  end

endmodule

// File: tb/tb_reglk_programmer.sv
// Directed bench for reglk_programmer with a small in-bench AXI-lite slave.
module tb_reglk_programmer;
  localparam int NB = 6;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            verify_en_i = 1'b0;
  logic [NB*32-1:0] lock_val_i = '0;
  logic            aw_valid_o, aw_ready_i;
  logic [AW-1:0]   aw_addr_o;
  logic            w_valid_o, w_ready_i;
  logic [DW-1:0]   w_data_o;
  logic [DW/8-1:0] w_strb_o;
  logic            b_valid_i, b_ready_o;
  logic [1:0]      b_resp_i;
  logic            ar_valid_o, ar_ready_i;
  logic [AW-1:0]   ar_addr_o;
  logic            r_valid_i, r_ready_o;
  logic [DW-1:0]   r_data_i;
  logic [1:0]      r_resp_i;
  logic            busy_o, done_o, error_o;
  logic [3:0]      err_idx_o;
  logic [1:0]      err_type_o;

  reglk_programmer #(.NB_REGS(NB), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BASE_ADDR('0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .verify_en_i(verify_en_i),
    .lock_val_i(lock_val_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_idx_o(err_idx_o), .err_type_o(err_type_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Slave knobs and bookkeeping
  int          aw_delay, bad_b_idx, zero_rd_idx;
  int          aw_wait, n_aw, n_w, n_b, n_ar, n_r, unstable, last_ar;
  logic        aw_seen, w_seen, ar_seen, b_fire, r_fire;
  logic [63:0] aw_first;
  logic [63:0] aw_log [16];
  logic [63:0] w_log  [16];
  logic [7:0]  strb_log [16];
  logic [63:0] ar_log [16];
  int          aw_vcyc [16];
  int          w_vcyc  [16];
  logic [63:0] mem [8];

  localparam logic [NB*32-1:0] LV  = {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [NB*32-1:0] LV2 = {32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_reset();
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
    ar_ready_i = 0; r_valid_i = 0; r_data_i = '0; r_resp_i = 0;
    aw_delay = 0; bad_b_idx = -1; zero_rd_idx = -1;
    aw_wait = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; unstable = 0; last_ar = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; b_fire = 0; r_fire = 0; aw_first = '0;
    for (int i = 0; i < 16; i++) begin
      aw_log[i] = '0; w_log[i] = '0; strb_log[i] = '0; ar_log[i] = '0;
      aw_vcyc[i] = 0; w_vcyc[i] = 0;
    end
    for (int i = 0; i < 8; i++) mem[i] = '0;
  endtask

  // One slave cycle: observe at the falling edge, drive inputs for the next rising edge.
  task automatic step();
    @(negedge clk_i);
    if (b_fire) begin b_valid_i = 0; b_resp_i = 0; b_fire = 0; end
    if (r_fire) begin r_valid_i = 0; r_data_i = '0; r_fire = 0; end
    if (aw_seen && w_seen) begin
      b_valid_i = 1;
      b_resp_i  = (n_b == bad_b_idx) ? 2'b10 : 2'b00;
      aw_seen = 0; w_seen = 0;
    end
    if (ar_seen) begin
      r_valid_i = 1;
      r_resp_i  = 2'b00;
      r_data_i  = (n_r == zero_rd_idx) ? 64'h0 : mem[last_ar & 7];
      ar_seen = 0;
    end
    if (b_valid_i && b_ready_o) begin b_fire = 1; n_b++; end
    if (r_valid_i && r_ready_o) begin r_fire = 1; n_r++; end
    aw_ready_i = 0;
    if (aw_valid_o && n_aw < 16) begin
      aw_vcyc[n_aw]++;
      if (aw_wait == 0) aw_first = aw_addr_o;
      else if (aw_addr_o !== aw_first) unstable++;
      if (aw_wait >= aw_delay) begin
        aw_ready_i = 1; aw_log[n_aw] = aw_addr_o; n_aw++; aw_seen = 1; aw_wait = 0;
      end else aw_wait++;
    end
    w_ready_i = w_valid_o;
    if (w_valid_o && n_w < 8) begin
      w_vcyc[n_w]++;
      w_log[n_w] = w_data_o; strb_log[n_w] = w_strb_o; mem[n_w] = w_data_o;
      n_w++; w_seen = 1;
    end
    ar_ready_i = ar_valid_o;
    if (ar_valid_o && n_ar < 16) begin
      ar_log[n_ar] = ar_addr_o; last_ar = int'(ar_addr_o >> 3); n_ar++; ar_seen = 1;
    end
  endtask

  task automatic run(input int max_steps, output int steps);
    steps = 0;
    while (!(done_o || error_o) && steps < max_steps) begin
      step();
      steps++;
    end
  endtask

  task automatic kick(input logic [NB*32-1:0] lv, input logic ver);
    @(negedge clk_i);
    lock_val_i = lv; verify_en_i = ver; start_i = 1;
    @(posedge clk_i);
    #1 start_i = 0;
  endtask

  initial begin
    int steps;
    slave_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o}, 0);
    chk("rst_awaddr", aw_addr_o, 0);
    chk("rst_araddr", ar_addr_o, 0);
    chk("rst_wdata", w_data_o, 0);
    chk("rst_strb", w_strb_o, 0);
    chk("rst_erridx", err_idx_o, 0);
    chk("rst_errtype", err_type_o, 0);
    rst_ni = 1;

    // Full program + verify with all readies immediate
    kick(LV, 1'b1);
    chk("seq_busy", busy_o, 1);
    run(200, steps);
    chk("seq_latency", steps, 25);
    chk("seq_done", done_o, 1);
    chk("seq_error", error_o, 0);
    chk("seq_busy_end", busy_o, 0);
    chk("seq_nwr", n_aw, 6);
    chk("seq_nb", n_b, 6);
    chk("seq_nrd", n_r, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("seq_awaddr%0d", i), aw_log[i], 64'(i * 8));
      chk($sformatf("seq_wdata%0d", i), w_log[i], 64'((i + 1) * 32'h11));
      chk($sformatf("seq_strb%0d", i), strb_log[i], 8'hFF);
      chk($sformatf("seq_araddr%0d", i), ar_log[i], 64'(i * 8));
    end

    // Delayed aw_ready, immediate w_ready, verify off; restart from DONE
    slave_reset();
    aw_delay = 3;
    kick(LV, 1'b0);
    chk("dly_done_clr", done_o, 0);
    run(200, steps);
    chk("dly_latency", steps, 31);
    chk("dly_done", done_o, 1);
    chk("dly_aw_cycles", aw_vcyc[0], 4);
    chk("dly_w_cycles", w_vcyc[0], 1);
    chk("dly_unstable", unstable, 0);
    chk("dly_nb", n_b, 6);
    chk("dly_nrd", n_ar, 0);
    chk("dly_awaddr3", aw_log[3], 64'h18);

    // Bad bresp on word 2
    slave_reset();
    bad_b_idx = 2;
    kick(LV, 1'b1);
    run(200, steps);
    chk("bresp_error", error_o, 1);
    chk("bresp_done", done_o, 0);
    chk("bresp_idx", err_idx_o, 2);
    chk("bresp_type", err_type_o, 2'b01);
    repeat (5) step();
    chk("bresp_no_aw", aw_valid_o, 0);
    chk("bresp_naw", n_aw, 3);
    chk("bresp_busy", busy_o, 0);
    chk("bresp_hold", error_o, 1);

    // Word 4 reads back as zero; restart from ERR
    slave_reset();
    zero_rd_idx = 4;
    kick(LV, 1'b1);
    chk("cmp_err_clr", {error_o, err_idx_o, err_type_o}, 0);
    run(200, steps);
    chk("cmp_error", error_o, 1);
    chk("cmp_idx", err_idx_o, 4);
    chk("cmp_type", err_type_o, 2'b11);
    chk("cmp_nrd", n_r, 5);

    // start pulse while busy must be ignored
    slave_reset();
    kick(LV, 1'b1);
    repeat (3) step();
    chk("ign_busy", busy_o, 1);
    start_i = 1; lock_val_i = LV2; verify_en_i = 0;
    step();
    start_i = 0;
    run(200, steps);
    chk("ign_latency", steps, 21);
    chk("ign_done", done_o, 1);
    chk("ign_nrd", n_r, 6);
    chk("ign_wdata0", w_log[0], 64'h11);
    chk("ign_wdata5", w_log[5], 64'h66);

    // Asynchronous reset during WR_RESP, then a clean restart
    slave_reset();
    kick(LV, 1'b1);
    step();
    @(posedge clk_i);
    #1;
    chk("rst_mid_bready", b_ready_o, 1);
    rst_ni = 0;
    #1;
    chk("rst_mid_outs", {busy_o, b_ready_o, aw_valid_o, w_valid_o, ar_valid_o, done_o, error_o}, 0);
    chk("rst_mid_addr", aw_addr_o, 0);
    slave_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
    chk("rst_no_resume", busy_o, 0);
    kick(LV, 1'b1);
    run(200, steps);
    chk("rst_restart_lat", steps, 25);
    chk("rst_restart_done", done_o, 1);
    chk("rst_restart_addr0", aw_log[0], 64'h0);
    chk("rst_restart_data0", w_log[0], 64'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
